// File: rtl/reflet_fpu_au_sched_pkg.sv
// reflet_fpu_au_sched_pkg
// Shared definitions for the reflet FPU arithmetic-unit scheduler.
// Holds the arithmetic unit opcodes that the scheduler and its clients use,
// the sequencer state encoding, and the default watchdog limit. The watchdog
// only exists when the build defines REFLET_FPU_AU_TIMEOUT_EN.
package reflet_fpu_au_sched_pkg;

    // Arithmetic unit opcodes. The scheduler forwards these without checking them.
    localparam logic [5:0] OPP_ADD = 6'h00;
    localparam logic [5:0] OPP_SUB = 6'h01;
    localparam logic [5:0] OPP_MUL = 6'h02;

    // Sequencer states.
    typedef enum logic [1:0] {
        SCHED_IDLE = 2'd0,
        SCHED_RUN  = 2'd1,
        SCHED_DONE = 2'd2
    } sched_state_t;

    // Default number of RUN cycles the watchdog allows before it aborts.
    localparam int SCHED_DEFAULT_TIMEOUT = 64;

    // Converts a one-hot two-way grant into the index of the client it selects.
    function automatic logic grant_id(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/reflet_fpu_rr_arbiter2.sv
// reflet_fpu_rr_arbiter2
// Combinational two-way round-robin picker.
// Ports:
//   i_req        request vector, bit i = client i
//   i_last_grant index of the client that won the previous arbitration
//   o_grant      one-hot grant, or zero when nobody is requesting
module reflet_fpu_rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // A lone requester always wins. On a tie the client that did not win
    // last time goes next.
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/reflet_fpu_au_sched.sv
// reflet_fpu_au_sched
// Two-client scheduler in front of the reflet FPU arithmetic unit. It
// arbitrates round-robin, latches the winning request, runs the unit's
// enable/ready handshake, and returns the result as a one-cycle pulse to the
// client that won.
// Optional feature: when the build defines REFLET_FPU_AU_TIMEOUT_EN, a watchdog
// aborts an operation after timeout_cycles RUN cycles (resp_err = 1, resp_data = 0).
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   req_valid/req_ready              per-client request and one-hot grant
//   req_opcode, req_in1..3           client requests, client 1 in the upper half
//   resp_valid, resp_data,
//   resp_flag, resp_err              response pulse and the held result
//   busy                             high in every state except IDLE
//   au_enable, au_opcode, au_in1..3  control and operands driven to the unit
//   au_ready, au_out, au_flag        handshake and result returned by the unit
module reflet_fpu_au_sched
    import reflet_fpu_au_sched_pkg::*;
#(
    parameter int float_size     = 32,
    parameter int timeout_cycles = SCHED_DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [11:0]             req_opcode,
    input  logic [2*float_size-1:0] req_in1,
    input  logic [2*float_size-1:0] req_in2,
    input  logic [2*float_size-1:0] req_in3,
    output logic [1:0]              resp_valid,
    output logic [float_size-1:0]   resp_data,
    output logic                    resp_flag,
    output logic                    resp_err,
    output logic                    busy,
    output logic                    au_enable,
    output logic [5:0]              au_opcode,
    output logic [float_size-1:0]   au_in1,
    output logic [float_size-1:0]   au_in2,
    output logic [float_size-1:0]   au_in3,
    input  logic                    au_ready,
    input  logic [float_size-1:0]   au_out,
    input  logic                    au_flag
);

    sched_state_t          r_state;
    sched_state_t          w_next_state;
    logic [1:0]            w_grant;
    logic                  w_take;
    logic                  w_timeout;
    logic                  r_last_grant;
    logic                  r_grant_id;
    logic [5:0]            r_au_opcode;
    logic [float_size-1:0] r_au_in1;
    logic [float_size-1:0] r_au_in2;
    logic [float_size-1:0] r_au_in3;
    logic [float_size-1:0] r_resp_data;
    logic                  r_resp_flag;

    reflet_fpu_rr_arbiter2 u_arbiter (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // A grant is only issued from IDLE. It is also gated by reset so that
    // req_ready stays low while reset is held, even if clients are requesting.
    assign w_take    = (r_state == SCHED_IDLE) && (|req_valid) && !reset;
    assign req_ready = w_take ? w_grant : 2'b00;

`ifdef REFLET_FPU_AU_TIMEOUT_EN
    localparam int CW = $clog2(timeout_cycles + 1);
    logic [CW-1:0] r_count;
    logic          r_resp_err;

    // The watchdog count is cleared at the grant so it reads zero in the first
    // RUN cycle. The abort fires in the RUN cycle where the count reaches the
    // limit, which places the abort pulse at T+2+timeout_cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_take) begin
            r_count <= '0;
        end else if (r_state == SCHED_RUN) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign w_timeout = (r_state == SCHED_RUN) && !au_ready &&
                       (r_count == CW'(timeout_cycles));
    assign resp_err  = r_resp_err;
`else
    // Without the watchdog, an operation the unit never finishes keeps the
    // block in RUN until reset. The timeout parameter is intentionally unused.
    logic w_unused_cfg;
    assign w_unused_cfg = (timeout_cycles != 0);
    assign w_timeout    = 1'b0;
    assign resp_err     = 1'b0;
`endif

    // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SCHED_IDLE: if (w_take) w_next_state = SCHED_RUN;
            SCHED_RUN:  if (au_ready || w_timeout) w_next_state = SCHED_DONE;
            SCHED_DONE: w_next_state = SCHED_IDLE;
            default:    w_next_state = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SCHED_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latch the winner's request at the grant. These registers drive the unit
    // directly, so later changes on the client side cannot reach it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_au_opcode  <= '0;
            r_au_in1     <= '0;
            r_au_in2     <= '0;
            r_au_in3     <= '0;
        end else if (w_take) begin
            r_last_grant <= grant_id(w_grant);
            r_grant_id   <= grant_id(w_grant);
            if (grant_id(w_grant)) begin
                r_au_opcode <= req_opcode[11:6];
                r_au_in1    <= req_in1[float_size +: float_size];
                r_au_in2    <= req_in2[float_size +: float_size];
                r_au_in3    <= req_in3[float_size +: float_size];
            end else begin
                r_au_opcode <= req_opcode[5:0];
                r_au_in1    <= req_in1[float_size-1:0];
                r_au_in2    <= req_in2[float_size-1:0];
                r_au_in3    <= req_in3[float_size-1:0];
            end
        end
    end

    // Result capture. The values are held until the next completion or abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resp_data <= '0;
            r_resp_flag <= 1'b0;
`ifdef REFLET_FPU_AU_TIMEOUT_EN
            r_resp_err  <= 1'b0;
`endif
        end else if ((r_state == SCHED_RUN) && au_ready) begin
            r_resp_data <= au_out;
            r_resp_flag <= au_flag;
`ifdef REFLET_FPU_AU_TIMEOUT_EN
            r_resp_err  <= 1'b0;
`endif
        end else if (w_timeout) begin
            r_resp_data <= '0;
            r_resp_flag <= 1'b0;
`ifdef REFLET_FPU_AU_TIMEOUT_EN
            r_resp_err  <= 1'b1;
`endif
        end
    end

    // The response pulse is decoded from the state. Because reset clears the
    // state asynchronously, an operation that reset interrupts produces no pulse.
    always_comb begin
        resp_valid = 2'b00;
        if (r_state == SCHED_DONE) begin
            resp_valid[r_grant_id] = 1'b1;
        end
    end

    assign au_enable = (r_state == SCHED_RUN);
    assign busy      = (r_state != SCHED_IDLE);
    assign au_opcode = r_au_opcode;
    assign au_in1    = r_au_in1;
    assign au_in2    = r_au_in2;
    assign au_in3    = r_au_in3;
    assign resp_data = r_resp_data;
    assign resp_flag = r_resp_flag;

endmodule

// File: tb/tb_reflet_fpu_au_sched.sv
// tb_reflet_fpu_au_sched
// Directed testbench for reflet_fpu_au_sched. A small behavioural model stands
// in for the arithmetic unit: ADD and SUB are ready in the first enabled cycle,
// MUL after MUL_LAT cycles, and any other opcode never becomes ready. The model
// returns hand-computed results for the known operand pairs and a XOR of the
// operands otherwise. Its flag output is bit 0 of operand 3.
module tb_reflet_fpu_au_sched;
    import reflet_fpu_au_sched_pkg::*;

    localparam int FS      = 32;
    localparam int TMO     = 16;
    localparam int MUL_LAT = 3;

    logic          clk;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [11:0]   req_opcode;
    logic [2*FS-1:0] req_in1, req_in2, req_in3;
    logic [1:0]    resp_valid;
    logic [FS-1:0] resp_data;
    logic          resp_flag;
    logic          resp_err;
    logic          busy;
    logic          au_enable;
    logic [5:0]    au_opcode;
    logic [FS-1:0] au_in1, au_in2, au_in3;
    logic          au_ready;
    logic [FS-1:0] au_out;
    logic          au_flag;

    int testsRun    = 0;
    int testsFailed = 0;
    int auCount     = 0;

    reflet_fpu_au_sched #(
        .float_size     (FS),
        .timeout_cycles (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .req_in3    (req_in3),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_flag  (resp_flag),
        .resp_err   (resp_err),
        .busy       (busy),
        .au_enable  (au_enable),
        .au_opcode  (au_opcode),
        .au_in1     (au_in1),
        .au_in2     (au_in2),
        .au_in3     (au_in3),
        .au_ready   (au_ready),
        .au_out     (au_out),
        .au_flag    (au_flag)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the arithmetic unit. It counts how many cycles enable has been
    // high and restarts the count whenever enable drops.
    always @(posedge clk) begin
        auCount <= au_enable ? auCount + 1 : 0;
    end

    function automatic logic [FS-1:0] auResult(input logic [5:0] op,
                                               input logic [FS-1:0] a, b, c);
        if (op == OPP_ADD && a == 32'h3F80_0000 && b == 32'h4000_0000)
            return 32'h4040_0000;
        if (op == OPP_MUL && a == 32'h4000_0000 && b == 32'h4040_0000)
            return 32'h40C0_0000;
        return a ^ b ^ c;
    endfunction

    always_comb begin
        au_ready = 1'b0;
        if (au_enable) begin
            case (au_opcode)
                OPP_ADD, OPP_SUB: au_ready = 1'b1;
                OPP_MUL:          au_ready = (auCount >= MUL_LAT);
                default:          au_ready = 1'b0;
            endcase
        end
        au_out  = auResult(au_opcode, au_in1, au_in2, au_in3);
        au_flag = au_in3[0];
    end

    // Drives both clients' requests, then waits for combinational outputs to settle.
    task automatic applyStimulus(input logic [1:0] v,
                                 input logic [5:0] op0, input logic [FS-1:0] a0, b0, c0,
                                 input logic [5:0] op1, input logic [FS-1:0] a1, b1, c1);
        req_valid  = v;
        req_opcode = {op1, op0};
        req_in1    = {a1, a0};
        req_in2    = {b1, b0};
        req_in3    = {c1, c0};
        #1;
    endtask

    // Moves to the next cycle's sampling point, just after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Guards against a hang if something in the run goes badly wrong.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int gId[5];
        int gCyc[5];
        int nGrant;
        int bothResp;
        int spurious;
        int lowBusy;

        // Reset state, with both clients already requesting.
        reset = 1'b1;
        applyStimulus(2'b11, OPP_ADD, 32'h3F80_0000, 32'h4000_0000, 0,
                             OPP_ADD, 32'h3F80_0000, 32'h4000_0000, 0);
        #2;
        checkOutput("rst_req_ready",  32'(req_ready),  0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 0);
        checkOutput("rst_resp_data",  resp_data,       0);
        checkOutput("rst_resp_err",   32'(resp_err),   0);
        checkOutput("rst_busy",       32'(busy),       0);
        checkOutput("rst_au_enable",  32'(au_enable),  0);
        checkOutput("rst_au_in1",     au_in1,          0);
        tick();
        tick();
        reset = 1'b0;
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Client 0 ADD. After the grant the client changes its operands; the
        // unit must keep seeing the latched operands.
        $display("[TB] client 0 ADD");
        applyStimulus(2'b01, OPP_ADD, 32'h3F80_0000, 32'h4000_0000, 0,
                             OPP_SUB, 32'h1111_1111, 0, 0);
        checkOutput("add_grant", 32'(req_ready), 32'h1);
        tick();
        applyStimulus(2'b00, OPP_SUB, 32'hFFFF_FFFF, 32'h1234_5678, 1,
                             OPP_SUB, 0, 0, 0);
        checkOutput("add_t1_enable",  32'(au_enable), 1);
        checkOutput("add_t1_in1",     au_in1, 32'h3F80_0000);
        checkOutput("add_t1_opcode",  32'(au_opcode), 32'(OPP_ADD));
        checkOutput("add_t1_resp",    32'(resp_valid), 0);
        tick();
        checkOutput("add_t2_enable",  32'(au_enable), 0);
        checkOutput("add_t2_resp",    32'(resp_valid), 32'h1);
        checkOutput("add_t2_data",    resp_data, 32'h4040_0000);
        checkOutput("add_t2_flag",    32'(resp_flag), 0);
        tick();
        checkOutput("add_t3_resp",    32'(resp_valid), 0);
        checkOutput("add_t3_busy",    32'(busy), 0);
        checkOutput("add_t3_hold",    resp_data, 32'h4040_0000);

        // Client 1 SUB with a latched-operand check, then a change after the grant.
        $display("[TB] client 1 SUB");
        applyStimulus(2'b10, 0, 0, 0, 0,
                             OPP_SUB, 32'h1234_5678, 32'h0F0F_0F0F, 0);
        checkOutput("sub_grant", 32'(req_ready), 32'h2);
        tick();
        applyStimulus(2'b00, 0, 0, 0, 0, OPP_SUB, 32'hFFFF_FFFF, 0, 0);
        tick();
        checkOutput("sub_resp", 32'(resp_valid), 32'h2);
        checkOutput("sub_data", resp_data, 32'h1D3B_5977);
        tick();

        // Client 1 MUL: enable held until ready, pulse one cycle after ready.
        $display("[TB] client 1 MUL");
        applyStimulus(2'b10, 0, 0, 0, 0,
                             OPP_MUL, 32'h4000_0000, 32'h4040_0000, 1);
        checkOutput("mul_grant", 32'(req_ready), 32'h2);
        tick();
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mul_t1_enable", 32'(au_enable), 1);
        checkOutput("mul_t1_opcode", 32'(au_opcode), 32'(OPP_MUL));
        tick();
        tick();
        checkOutput("mul_t3_enable", 32'(au_enable), 1);
        checkOutput("mul_t3_resp",   32'(resp_valid), 0);
        tick();
        checkOutput("mul_t4_enable", 32'(au_enable), 1);
        tick();
        checkOutput("mul_t5_enable", 32'(au_enable), 0);
        checkOutput("mul_t5_resp",   32'(resp_valid), 32'h2);
        checkOutput("mul_t5_data",   resp_data, 32'h40C0_0000);
        checkOutput("mul_t5_flag",   32'(resp_flag), 1);
        tick();
        checkOutput("mul_t6_busy",   32'(busy), 0);

        // Both clients request continuously. Client 1 won last, so client 0
        // goes first, then the grants alternate three cycles apart.
        $display("[TB] round robin");
        foreach (gId[k]) begin
            gId[k]  = 99;
            gCyc[k] = -99;
        end
        nGrant   = 0;
        bothResp = 0;
        applyStimulus(2'b11, OPP_ADD, 32'h3F80_0000, 32'h4000_0000, 0,
                             OPP_ADD, 32'h3F80_0000, 32'h4000_0000, 0);
        for (int c = 0; c < 14; c++) begin
            if (req_ready != 2'b00 && nGrant < 5) begin
                gId[nGrant]  = int'(req_ready[1]);
                gCyc[nGrant] = c;
                nGrant++;
            end
            if (resp_valid == 2'b11) bothResp++;
            tick();
        end
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("rr_grant0", gId[0], 0);
        checkOutput("rr_grant1", gId[1], 1);
        checkOutput("rr_grant2", gId[2], 0);
        checkOutput("rr_grant3", gId[3], 1);
        checkOutput("rr_first_cycle", gCyc[0], 0);
        for (int k = 1; k < 4; k++)
            checkOutput($sformatf("rr_spacing%0d", k), gCyc[k] - gCyc[k-1], 3);
        checkOutput("rr_both_resp", bothResp, 0);

        // Reset during a MUL: outputs drop while reset is still high, the
        // interrupted result never appears, and the next request works.
        $display("[TB] reset during MUL");
        applyStimulus(2'b01, OPP_MUL, 32'h4000_0000, 32'h4040_0000, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("rmul_enable_before", 32'(au_enable), 1);
        reset = 1'b1;
        applyStimulus(2'b01, OPP_ADD, 32'h3F80_0000, 32'h4000_0000, 0, 0, 0, 0, 0);
        checkOutput("rmul_enable", 32'(au_enable), 0);
        checkOutput("rmul_busy",   32'(busy), 0);
        checkOutput("rmul_ready",  32'(req_ready), 0);
        tick();
        reset = 1'b0;
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        spurious = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid != 2'b00) spurious++;
            tick();
        end
        checkOutput("rmul_no_resp", spurious, 0);
        checkOutput("rmul_data_cleared", resp_data, 0);
        applyStimulus(2'b11, OPP_ADD, 32'h3F80_0000, 32'h4000_0000, 0,
                             OPP_SUB, 32'h5555_5555, 0, 0);
        checkOutput("rmul_tie_after_reset", 32'(req_ready), 32'h1);
        tick();
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("rmul_next_resp", 32'(resp_valid), 32'h1);
        checkOutput("rmul_next_data", resp_data, 32'h4040_0000);
        tick();

        // Unknown opcode from client 1.
        $display("[TB] unknown opcode");
        applyStimulus(2'b10, 0, 0, 0, 0, 6'h3F, 32'hDEAD_BEEF, 32'h1, 32'h1);
        checkOutput("unk_grant", 32'(req_ready), 32'h2);
        tick();
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef REFLET_FPU_AU_TIMEOUT_EN
        for (int k = 0; k < TMO; k++) tick();
        checkOutput("tmo_t17_enable", 32'(au_enable), 1);
        checkOutput("tmo_t17_resp",   32'(resp_valid), 0);
        tick();
        checkOutput("tmo_resp",  32'(resp_valid), 32'h2);
        checkOutput("tmo_err",   32'(resp_err), 1);
        checkOutput("tmo_data",  resp_data, 0);
        tick();
        applyStimulus(2'b01, OPP_ADD, 32'h3F80_0000, 32'h4000_0000, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("tmo_next_resp", 32'(resp_valid), 32'h1);
        checkOutput("tmo_next_err",  32'(resp_err), 0);
        checkOutput("tmo_next_data", resp_data, 32'h4040_0000);
`else
        lowBusy = 0;
        for (int k = 0; k < 100; k++) begin
            if (!busy || resp_valid != 2'b00) lowBusy++;
            tick();
        end
        checkOutput("stuck_busy", lowBusy, 0);
        checkOutput("stuck_err",  32'(resp_err), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(2'b01, OPP_ADD, 32'h3F80_0000, 32'h4000_0000, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("stuck_next_resp", 32'(resp_valid), 32'h1);
        checkOutput("stuck_next_data", resp_data, 32'h4040_0000);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/reflet_fpu_au_sched.md
# reflet_fpu_au_sched

Two-requester scheduler for the reflet FPU arithmetic unit. Accepts operation requests (opcode + three operands) from two independent clients, such as the integer-core FPU port and a vector/DMA helper. Arbitrates between them round-robin and sequences the arithmetic unit's enable/ready protocol. Returns the result to the winning client as a one-cycle response pulse. Sits between the clients and the arithmetic unit instance and owns that unit's control inputs.

## Interface
Parameters:
- float_size, 32, float width in bits
- timeout_cycles, 64, watchdog limit; used only with REFLET_FPU_AU_TIMEOUT_EN

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  2  request present, bit i = client i
- req_ready  out  2  grant/accept, one-hot or zero
- req_opcode  in  12  {client1[5:0], client0[5:0]}
- req_in1, req_in2, req_in3  in  2*float_size each  operands, client1 in upper half
- resp_valid  out  2  one-cycle result pulse to client i
- resp_data  out  float_size  result, shared by both clients
- resp_flag  out  1  arithmetic unit flag_out, captured
- resp_err  out  1  timeout abort (0 when macro absent)
- busy  out  1  high in any state except IDLE
- au_enable  out  1  to arithmetic unit enable
- au_opcode  out  6  to arithmetic unit opcode
- au_in1, au_in2, au_in3  out  float_size  to arithmetic unit operands
- au_ready  in  1  from arithmetic unit ready
- au_out  in  float_size  from arithmetic unit flt_out
- au_flag  in  1  from arithmetic unit flag_out

## Operation
- State machine IDLE → RUN → DONE → IDLE.
- IDLE:
  - If any req_valid is set, assert req_ready for the winner combinationally.
  - Latch the winner's opcode and operands into au_* registers, record the grant id, go to RUN.
- Arbitration:
  - A single requester always wins.
  - When both request, the client not granted last wins.
  - last_grant resets to 1, so client 0 wins the first tie.
- RUN:
  - au_enable = 1; operands are held stable.
  - When au_ready is sampled 1: capture au_out into resp_data and au_flag into resp_flag, then go to DONE.
- DONE:
  - au_enable = 0, which flushes the unit's internal multiplier/fisqrt state.
  - resp_valid[grant id] = 1 for exactly this cycle.
  - No grant is issued in DONE. Next state is IDLE.
- Clients hold req_valid and operands until req_ready. Changes to req_* after the grant are ignored.
- resp_data, resp_flag and resp_err hold their values until the next capture.
- Unknown opcodes are passed through unchecked. The arithmetic unit never raises ready for them, so RUN persists until reset unless the timeout feature is compiled in.

## Timing
- Reset values: every output is 0, state is IDLE, last_grant = 1.
- Let the grant be in cycle T, and let L be the number of cycles from au_enable rising to au_ready high (L = 0 for ADD/SUB).
- resp_valid is high in cycle T+2+L.
- The earliest next grant is T+3+L. Minimum issue interval is 3 cycles.
- au_enable is high during cycles T+1 … T+1+L, and is low for at least one cycle between operations.
- Reset mid-operation: state returns to IDLE immediately and au_enable drops asynchronously. The in-flight result is discarded and no resp_valid is generated.
- A request arriving in RUN or DONE waits for IDLE; arbitration uses the requests present in that IDLE cycle.

## Configuration
- REFLET_FPU_AU_TIMEOUT_EN defined:
  - A cycle counter clears on entry to RUN and increments each RUN cycle.
  - When it reaches timeout_cycles without au_ready, the block goes to DONE with resp_err = 1 and resp_data = 0.
  - resp_err is 0 on every normal completion.
- Macro absent: no counter, resp_err tied to 0, and RUN waits indefinitely.

## Structure
- reflet_fpu.vh holds the OPP_* opcodes (existing), the state encodings (SCHED_IDLE/RUN/DONE) and the default timeout constant.
- Sub-module reflet_fpu_rr_arbiter2: combinational two-way round-robin picker; inputs are the request vector and last_grant, output is a one-hot grant.
- The sequencer FSM, operand/result registers and watchdog live in the top module.

## Test plan
- Client 0, ADD 0x3F800000 + 0x40000000 granted at T → resp_valid[0] at T+2, resp_data 0x40400000, au_enable high only in T+1.
- Client 1, MUL 0x40000000 × 0x40400000 → au_enable held until au_ready; resp_valid[1] one cycle after au_ready, resp_data 0x40C00000.
- Both clients continuously requesting ADD → grants 0,1,0,1 with grant-to-grant spacing of 3 cycles; never two resp_valid bits high together.
- Reset asserted during RUN of a MUL → au_enable, busy and req_ready are 0 before the next edge, no resp_valid; the next request completes normally.
- With the macro defined, timeout_cycles = 16, opcode 6'h3F → resp_valid at T+2+16 with resp_err = 1 and resp_data 0. Without the macro, busy stays 1 for 100 cycles.
- Client 0 changes its operands after the grant → result reflects the latched operands.
